// File: rtl/vga_pixel_fetch.sv
// Display-port requester for the SRAM interface: paces vga_flag reads, buffers returned pixels
// in a small FIFO and serves them to the VGA output stage. Option macro: VGA_FETCH_REPEAT_EN.
module vga_pixel_fetch #(
  parameter int PIX_W        = 24,
  parameter int DEPTH        = 16,
  parameter int LOG_DEPTH    = 4,
  parameter int RD_LATENCY   = 3,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  output logic               vga_flag,
  input  logic               done_vga,
  input  logic [PIX_W-1:0]   vga_pixel,
  input  logic               pix_req,
  output logic [PIX_W-1:0]   pix_out,
  output logic               pix_valid,
  output logic [LOG_DEPTH:0] fifo_level,
  output logic               underflow
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, FLUSH} state_e;

  localparam int                    FL_W       = $clog2(RD_LATENCY + 2);
  localparam logic [LOG_DEPTH+1:0]  DEPTH_X    = (LOG_DEPTH+2)'(DEPTH);
  localparam logic [LOG_DEPTH:0]    FULL_LVL   = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]      FRAME_N    = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]      FRAME_LAST = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [FL_W-1:0]       FL_LAST    = FL_W'(RD_LATENCY);

  state_e               state_q, state_d;
  logic [FL_W-1:0]      fl_cnt_q, fl_cnt_d;
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   level_q, level_d, outst_q, outst_d;
  logic [CNT_W-1:0]     req_cnt_q, req_cnt_d;
  logic [PIX_W-1:0]     pix_q, pix_d;
  logic                 pix_vld_q, pix_vld_d, unf_q, unf_d;
  logic [PIX_W-1:0]     mem_q [DEPTH];

  logic                 in_flush, wr_en, rd_en;
  logic [LOG_DEPTH+1:0] committed;

  // Reads still in flight are counted against free space so late returns always fit.
  assign in_flush  = (state_q == FLUSH);
  assign committed = {1'b0, level_q} + {1'b0, outst_q};
  assign vga_flag  = (state_q == FETCH) && (committed < DEPTH_X) && (req_cnt_q < FRAME_N);
  assign wr_en     = done_vga && !in_flush;
  assign rd_en     = pix_req && !in_flush && (level_q != '0);

  always_comb begin
    state_d   = state_q;
    fl_cnt_d  = fl_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    req_cnt_d = req_cnt_q;
    pix_d     = pix_q;
    pix_vld_d = pix_vld_q;
    unf_d     = unf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
    level_d = level_q + (LOG_DEPTH+1)'(wr_en) - (LOG_DEPTH+1)'(rd_en);
    outst_d = outst_q + (LOG_DEPTH+1)'(vga_flag)
                      - (LOG_DEPTH+1)'(wr_en && (outst_q != '0));
    if (vga_flag) req_cnt_d = req_cnt_q + CNT_W'(1);

    if (pix_req) begin
      if (rd_en) begin
        pix_d     = mem_q[rd_ptr_q];
        pix_vld_d = 1'b1;
      end else begin
`ifdef VGA_FETCH_REPEAT_EN
        pix_d     = pix_q;
`else
        pix_d     = '0;
`endif
        pix_vld_d = 1'b0;
        if (!in_flush) unf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: ;
      FETCH: if (vga_flag && (req_cnt_q == FRAME_LAST)) state_d = DONE;
      FLUSH: begin
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        level_d   = '0;
        outst_d   = '0;
        req_cnt_d = '0;
        unf_d     = 1'b0;
        fl_cnt_d  = fl_cnt_q + FL_W'(1);
        if (fl_cnt_q == FL_LAST) state_d = FETCH;
      end
    endcase

    if (frame_start) begin
      state_d  = FLUSH;
      fl_cnt_d = '0;
      unf_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      fl_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      outst_q   <= '0;
      req_cnt_q <= '0;
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fl_cnt_q  <= fl_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      outst_q   <= outst_d;
      req_cnt_q <= req_cnt_d;
      pix_q     <= pix_d;
      pix_vld_q <= pix_vld_d;
      unf_q     <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= vga_pixel;
  end

  assign pix_out    = pix_q;
  assign pix_valid  = pix_vld_q;
  assign fifo_level = level_q;
  assign underflow  = unf_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(wr_en && (level_q == FULL_LVL) && !rd_en))
    else $error("vga_pixel_fetch: FIFO write while full");

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: directed vector table, hand-written corner sequences and
// randomized frames, all checked against a queue-based model of the fetch/FIFO rules.
module tb_vga_pixel_fetch;

  localparam int PIX_W = 24, DEPTH = 16, LOG_DEPTH = 4, RD_LATENCY = 3, FRAME = 24;
`ifdef VGA_FETCH_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  localparam logic [PIX_W-1:0] REP = REPEAT ? 24'hABCDEF : 24'h0;

  logic clock = 1'b0, reset = 1'b1, frame_start = 1'b0, done_vga = 1'b0, pix_req = 1'b0;
  logic [PIX_W-1:0] vga_pixel = '0, pix_out;
  logic vga_flag, pix_valid, underflow;
  logic [LOG_DEPTH:0] fifo_level;

  vga_pixel_fetch #(.PIX_W(PIX_W), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH),
    .RD_LATENCY(RD_LATENCY), .FRAME_PIXELS(FRAME), .CNT_W(19)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .vga_flag(vga_flag),
    .done_vga(done_vga), .vga_pixel(vga_pixel), .pix_req(pix_req), .pix_out(pix_out),
    .pix_valid(pix_valid), .fifo_level(fifo_level), .underflow(underflow));

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: frame phase, pixel queue, reads in flight, reads issued this frame.
  typedef enum {M_IDLE, M_FETCH, M_DONE, M_FLUSH} mst_e;
  mst_e m_st;
  int m_fl, m_out, m_req;
  logic [PIX_W-1:0] m_q[$];
  logic [PIX_W-1:0] m_pix;
  bit m_vld, m_unf;

  function automatic bit m_flag();
    return (m_st == M_FETCH) && ((m_q.size() + m_out) < DEPTH) && (m_req < FRAME);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_fl = 0; m_out = 0; m_req = 0; m_q.delete();
    m_pix = '0; m_vld = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_next(input bit fs, input bit dn, input logic [PIX_W-1:0] px, input bit rq);
    bit f, fl;
    f  = m_flag();
    fl = (m_st == M_FLUSH);
    if (rq) begin
      if (!fl && m_q.size() > 0) begin
        m_pix = m_q.pop_front(); m_vld = 1'b1;
      end else begin
        if (!REPEAT) m_pix = '0;
        m_vld = 1'b0;
        if (!fl) m_unf = 1'b1;
      end
    end
    if (dn && !fl) begin
      m_q.push_back(px);
      if (m_out > 0) m_out--;
    end
    if (f) begin m_out++; m_req++; end
    if (m_st == M_FETCH && f && m_req == FRAME) m_st = M_DONE;
    if (fl) begin
      m_q.delete(); m_out = 0; m_req = 0; m_unf = 1'b0;
      if (m_fl == RD_LATENCY) m_st = M_FETCH;
      m_fl++;
    end
    if (fs) begin m_st = M_FLUSH; m_fl = 0; m_unf = 1'b0; end
  endtask

  task automatic chk_all();
    chk("vga_flag", 32'(vga_flag), 32'(m_flag()));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("pix_out", 32'(pix_out), 32'(m_pix));
    chk("pix_valid", 32'(pix_valid), 32'(m_vld));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // Memory responder: each flag cycle returns one done_vga 'lat' cycles later, in order.
  int due_q[$];
  int lat = 3, flag_cnt = 0;
  bit resp_en = 1'b1, seq_mode = 1'b0, last_dn = 1'b0, man_dn = 1'b0;
  logic [PIX_W-1:0] next_pix = 24'd1, man_px = '0;

  task automatic step(input bit fs, input bit rq);
    bit dn;
    logic [PIX_W-1:0] px;
    chk_all();
    dn = 1'b0; px = '0;
    if (resp_en) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        dn = 1'b1;
        px = seq_mode ? next_pix : 24'($urandom);
        next_pix++;
      end
      if (vga_flag) due_q.push_back(cyc + lat);
    end else begin
      dn = man_dn; px = man_px;
    end
    last_dn = dn;
    if (vga_flag) flag_cnt++;
    frame_start = fs; pix_req = rq; done_vga = dn; vga_pixel = px;
    model_next(fs, dn, px, rq);
    @(posedge clock); #1; cyc++;
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; done_vga = 1'b0; pix_req = 1'b0; vga_pixel = '0;
    #2;
    model_reset(); due_q.delete();
    chk_all();
    @(posedge clock); #1; cyc++;
    reset = 1'b0;
  endtask

  typedef struct {
    bit fs, dn, rq; logic [PIX_W-1:0] px;
    bit e_flag; int e_lvl; bit e_vld; logic [PIX_W-1:0] e_out; bit e_unf;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1, 0, 0, 24'h0,      0, 0, 0, 24'h0,      0};
    tbl[1]  = '{0, 0, 1, 24'h0,      0, 0, 0, 24'h0,      0};
    tbl[2]  = '{0, 1, 0, 24'h111,    0, 0, 0, 24'h0,      0};
    tbl[3]  = '{0, 0, 0, 24'h0,      0, 0, 0, 24'h0,      0};
    tbl[4]  = '{0, 0, 0, 24'h0,      1, 0, 0, 24'h0,      0};
    tbl[5]  = '{0, 0, 0, 24'h0,      1, 0, 0, 24'h0,      0};
    tbl[6]  = '{0, 1, 0, 24'hABCDEF, 1, 1, 0, 24'h0,      0};
    tbl[7]  = '{0, 0, 1, 24'h0,      1, 0, 1, 24'hABCDEF, 0};
    tbl[8]  = '{0, 0, 1, 24'h0,      1, 0, 0, REP,        1};
    tbl[9]  = '{1, 0, 0, 24'h0,      0, 0, 0, REP,        0};
    tbl[10] = '{0, 0, 1, 24'h0,      0, 0, 0, REP,        0};

    #1;
    do_reset();

    // Directed vectors: flush window, discarded done, flag restart, read, underflow, clear.
    resp_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      man_dn = tbl[i].dn; man_px = tbl[i].px;
      step(tbl[i].fs, tbl[i].rq);
      chk($sformatf("tbl%0d_flag", i), 32'(vga_flag), 32'(tbl[i].e_flag));
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_valid", i), 32'(pix_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_pix", i), 32'(pix_out), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].e_unf));
    end
    resp_en = 1'b0; man_dn = 1'b0; resp_en = 1'b1;

    // Pacing: no consumer, 3-cycle returns; flag must stop with exactly DEPTH buffered.
    do_reset(); lat = 3; flag_cnt = 0;
    step(1'b1, 1'b0);
    for (int c = 0; c < 40; c++) step(1'b0, 1'b0);
    chk("pacing_level", 32'(fifo_level), 32'(DEPTH));
    chk("pacing_flag", 32'(vga_flag), 32'h0);
    chk("pacing_flag_cycles", 32'(flag_cnt), 32'(DEPTH));

    // Flush: frame_start with level 6 and two reads in flight (2-cycle returns).
    do_reset(); lat = 2;
    step(1'b1, 1'b0);
    for (int c = 0; c < 40 && fifo_level != 5'd6; c++) step(1'b0, 1'b0);
    chk("flush_pre_level", 32'(fifo_level), 32'd6);
    chk("flush_pre_flag", 32'(vga_flag), 32'h1);
    begin
      int k;
      step(1'b1, 1'b0);
      k = 1;
      while (!vga_flag && k < 12) begin step(1'b0, 1'b0); k++; end
      chk("flush_reassert_delay", 32'(k), 32'(RD_LATENCY + 2));
      chk("flush_level", 32'(fifo_level), 32'h0);
      chk("flush_underflow", 32'(underflow), 32'h0);
    end

    // Streaming and frame end: pixels 1..FRAME in order, then one underflowing request.
    do_reset(); lat = 3; seq_mode = 1'b1; next_pix = 24'd1; flag_cnt = 0;
    step(1'b1, 1'b0);
    for (int c = 0; c < 20 && !last_dn; c++) step(1'b0, 1'b0);
    chk("stream_first_done", 32'(last_dn), 32'h1);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    for (int j = 1; j <= FRAME + 1; j++) begin
      step(1'b0, 1'b1);
      if (j <= FRAME) begin
        chk($sformatf("stream_pix%0d", j), 32'(pix_out), 32'(j));
        chk($sformatf("stream_valid%0d", j), 32'(pix_valid), 32'h1);
        if (j == FRAME) chk("stream_underflow", 32'(underflow), 32'h0);
      end else begin
        chk("frame_end_valid", 32'(pix_valid), 32'h0);
        chk("frame_end_underflow", 32'(underflow), 32'h1);
        chk("frame_end_pix", 32'(pix_out), 32'(REPEAT ? FRAME : 0));
      end
    end
    chk("frame_flag_cycles", 32'(flag_cnt), 32'(FRAME));
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0);
    chk("frame_done_flag", 32'(vga_flag), 32'h0);
    seq_mode = 1'b0;

    // Reset mid-FETCH with 5 pixels buffered; flag stays low until a new frame_start.
    do_reset(); lat = 3;
    step(1'b1, 1'b0);
    for (int c = 0; c < 40 && fifo_level != 5'd5; c++) step(1'b0, 1'b0);
    chk("rst_pre_level", 32'(fifo_level), 32'd5);
    chk("rst_pre_flag", 32'(vga_flag), 32'h1);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1'b0, c[0]);
      chk("rst_idle_flag", 32'(vga_flag), 32'h0);
    end

    // Randomized frames, including frame_start mid-FETCH and inside FLUSH.
    do_reset();
    for (int f = 0; f < 30; f++) begin
      int len, p;
      len = $urandom_range(6, 90);
      p   = $urandom_range(0, 100);
      step(1'b1, $urandom_range(0, 99) < p);
      lat = $urandom_range(1, RD_LATENCY);
      for (int c = 0; c < len; c++) step(1'b0, $urandom_range(0, 99) < p);
    end
    chk_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
